// File: rtl/data_write_buffer_pkg.sv
// Shared definitions for the posted-store write buffer: default depth,
// pointer width and the queued-entry layout.
package wb_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int PTR_W = $clog2(DEFAULT_DEPTH);

    // Start of the data segment; data_mem filters writes, the buffer does not.
    localparam logic [31:0] DATA_START = 32'h1000_0000;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/data_write_buffer_if.sv
// Core-side and data_mem-side signals of the write buffer; the buffer takes
// the slave modport, the core/memory environment the master modport.
interface data_write_buffer_if;

    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic        cpu_sync;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        empty;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data_out;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_sync, mem_data_out,
        output cpu_rdata, cpu_stall, empty, mem_addr, mem_data_in, mem_read, mem_write
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_sync, mem_data_out,
        input  cpu_rdata, cpu_stall, empty, mem_addr, mem_data_in, mem_read, mem_write
    );

endinterface

// File: rtl/data_write_buffer_fwd_match.sv
// Combinational search for the youngest queued store whose word address
// matches the lookup address.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  wb_entry_t                entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic [29:0]              lookup_addr,
    output logic                     hit,
    output logic [31:0]              data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk from oldest to youngest so the last match found wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + i[PW-1:0];
            if (((PW+1)'(i) < count) && (entries[idx].addr == lookup_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/data_write_buffer.sv
// Posted-store write buffer between the core's memory stage and data_mem:
// queues stores, forwards loads from queued data, drains on spare cycles.
module data_write_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input logic                clk,
    input logic                reset,
    data_write_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    wb_entry_t     entries [DEPTH];
    wb_entry_t     head_entry;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic        full;
    logic        is_empty;
    logic        idle;
    logic        drain;
    logic        stall;
    logic        push;
    logic        load;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    assign head_entry = entries[head];
    assign full       = (count == FULL_COUNT);
    assign is_empty   = (count == '0);
    assign idle       = !bus.cpu_read && !bus.cpu_write;

    // A full store or a sync stalls, so a push and a pop never share a cycle.
    assign stall = (bus.cpu_write && full) || (bus.cpu_sync && !is_empty);
    assign drain = !is_empty && (idle || bus.cpu_sync || (bus.cpu_write && full));
    assign push  = bus.cpu_write && !stall;
    assign load  = bus.cpu_read && !bus.cpu_write && !stall;

    wb_fwd_match #(
        .DEPTH(DEPTH)
    ) u_fwd_match (
        .entries    (entries),
        .head       (head),
        .count      (count),
        .lookup_addr(bus.cpu_addr[31:2]),
        .hit        (fwd_hit),
        .data       (fwd_data)
    );

    assign bus.cpu_stall   = stall;
    assign bus.empty       = is_empty;
    assign bus.cpu_rdata   = fwd_hit ? fwd_data : bus.mem_data_out;
    assign bus.mem_read    = load && !fwd_hit;
    assign bus.mem_write   = drain;
    assign bus.mem_addr    = drain ? {head_entry.addr, 2'b00} : bus.cpu_addr;
    assign bus.mem_data_in = drain ? head_entry.data : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push) begin
            entries[tail] <= '{addr: bus.cpu_addr[31:2], data: bus.cpu_wdata};
            tail          <= tail + 1'b1;
            count         <= count + 1'b1;
        end else if (drain) begin
            head  <= head + 1'b1;
            count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_data_write_buffer.sv
// Directed and random checks of data_write_buffer against a queue-based
// reference model and a small data_mem model.
module tb_data_write_buffer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_write_buffer_if bus ();

    data_write_buffer #(
        .DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] dm      [16];
    logic [31:0] exp_mem [16];
    wr_t         wlog[$];
    wr_t         exp_writes[$];
    wr_t         q[$];
    wr_t         wtmp;
    int          n_checks = 0;
    int          n_fail   = 0;

    // data_mem stand-in: combinational read, write on posedge, logs every write.
    always_comb bus.mem_data_out = dm[bus.mem_addr[5:2]];

    always @(posedge clk) begin
        if (bus.mem_write) begin
            dm[bus.mem_addr[5:2]] = bus.mem_data_in;
            wtmp.addr = bus.mem_addr;
            wtmp.data = bus.mem_data_in;
            wlog.push_back(wtmp);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One core cycle: drive, check against the model at negedge, then advance the model.
    task automatic cycle(input logic rd, input logic wr, input logic sy,
                         input logic [31:0] a, input logic [31:0] d, output logic stalled);
        logic        full, drain, exp_stall, load, hit;
        logic [31:0] fd;
        int          n;
        wr_t         e;
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        bus.cpu_sync  = sy;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        @(negedge clk);
        n         = q.size();
        full      = (n == 4);
        exp_stall = (wr && full) || (sy && n > 0);
        drain     = (n > 0) && ((!rd && !wr) || sy || (wr && full));
        stalled   = bus.cpu_stall;
        check("stall", bus.cpu_stall, exp_stall);
        check("empty", bus.empty, n == 0);
        check("mem_write", bus.mem_write, drain);
        if (drain) begin
            check("drain_addr", bus.mem_addr, {q[0].addr[31:2], 2'b00});
            check("drain_data", bus.mem_data_in, q[0].data);
        end else begin
            check("mem_addr", bus.mem_addr, a);
            check("mem_data_in", bus.mem_data_in, 32'h0);
        end
        load = rd && !wr && !exp_stall;
        if (load) begin
            hit = 1'b0;
            fd  = '0;
            for (int i = n - 1; i >= 0; i--) begin
                if (q[i].addr[31:2] == a[31:2]) begin
                    hit = 1'b1;
                    fd  = q[i].data;
                    break;
                end
            end
            if (hit) begin
                check("fwd_data", bus.cpu_rdata, fd);
                check("fwd_mem_read", bus.mem_read, 1'b0);
            end else begin
                check("miss_mem_read", bus.mem_read, 1'b1);
                check("miss_data", bus.cpu_rdata, exp_mem[a[5:2]]);
            end
        end else begin
            check("mem_read_quiet", bus.mem_read, 1'b0);
        end
        @(posedge clk);
        #1;
        if (drain) begin
            exp_mem[q[0].addr[5:2]] = q[0].data;
            e.addr = {q[0].addr[31:2], 2'b00};
            e.data = q[0].data;
            exp_writes.push_back(e);
            void'(q.pop_front());
        end
        if (wr && !exp_stall) begin
            e.addr = a;
            e.data = d;
            q.push_back(e);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
        logic st;
        stalls = 0;
        repeat (20) begin
            cycle(1'b0, 1'b1, 1'b0, a, d, st);
            if (!st) return;
            stalls++;
        end
        check("store_timeout", bus.cpu_stall, 1'b0);
    endtask

    task automatic do_sync(output int stalls);
        logic st;
        stalls = 0;
        repeat (20) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h1000_0000, 32'h0, st);
            if (!st) return;
            stalls++;
        end
        check("sync_timeout", bus.cpu_stall, 1'b0);
    endtask

    task automatic do_load(input logic [31:0] a);
        logic st;
        cycle(1'b1, 1'b0, 1'b0, a, 32'h0, st);
    endtask

    task automatic do_idle();
        logic st;
        cycle(1'b0, 1'b0, 1'b0, 32'h1000_0000, 32'h0, st);
    endtask

    initial begin
        int          s;
        int          base;
        int          r;
        logic        rd, wr, sy, st;
        logic [31:0] a, d;

        reset         = 1'b1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_sync  = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            dm[i]      = 32'hA500_0000 + i;
            exp_mem[i] = 32'hA500_0000 + i;
        end
        #2;
        check("rst_empty", bus.empty, 1'b1);
        check("rst_stall", bus.cpu_stall, 1'b0);
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_mem_read", bus.mem_read, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset with two stores queued: nothing may ever reach data_mem.
        do_store(32'h1000_0000, 32'h1111_1111, s);
        do_store(32'h1000_0004, 32'h2222_2222, s);
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_sync  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_empty", bus.empty, 1'b1);
        check("midrst_mem_write", bus.mem_write, 1'b0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        do_idle();
        check("midrst_no_writes", wlog.size(), 0);

        // Store then forward, then drain on idle.
        do_store(32'h1000_0004, 32'hCAFE_F00D, s);
        do_load(32'h1000_0004);
        do_idle();
        check("fwd_drained_empty", bus.empty, 1'b1);
        check("fwd_mem_word", dm[1], 32'hCAFE_F00D);

        // Youngest match wins; drains keep order.
        base = wlog.size();
        do_store(32'h1000_0008, 32'h1, s);
        do_store(32'h1000_0008, 32'h2, s);
        do_load(32'h1000_0008);
        do_idle();
        do_idle();
        check("young_mem_word", dm[2], 32'h2);
        check("young_first_write", wlog[base].data, 32'h1);
        check("young_second_write", wlog[base+1].data, 32'h2);

        // Five back-to-back stores: only the fifth stalls, once.
        base = wlog.size();
        for (int i = 0; i < 5; i++) begin
            do_store(32'h1000_0020 + 4 * i, 32'h50 + i, s);
            check($sformatf("full_stalls_%0d", i), s, (i == 4) ? 1 : 0);
        end
        do_sync(s);
        check("full_sync_stalls", s, 4);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("full_order_%0d", i), wlog[base+i].data, 32'h50 + i);
        end

        // Sync with three entries stalls exactly three cycles.
        for (int i = 0; i < 3; i++) do_store(32'h1000_000C + 4 * i, 32'hD0 + i, s);
        do_sync(s);
        check("sync_stalls", s, 3);
        check("sync_empty", bus.empty, 1'b1);

        // Load miss with a non-matching entry queued.
        do_store(32'h1000_0010, 32'hBEEF_0010, s);
        do_load(32'h1000_0020);
        do_sync(s);

        // Random traffic; a stalled request is held until accepted.
        st = 1'b0;
        rd = 1'b0; wr = 1'b0; sy = 1'b0; a = 32'h1000_0000; d = 32'h0;
        for (int k = 0; k < 400; k++) begin
            if (!st) begin
                r  = int'($urandom_range(0, 99));
                rd = (r >= 40 && r < 75);
                wr = (r < 40) || (r >= 95);
                sy = (r >= 90);
                a  = 32'h1000_0000 | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
                d  = $urandom;
            end
            cycle(rd, wr, sy, a, d, st);
        end
        do_sync(s);

        check("log_size", wlog.size(), exp_writes.size());
        for (int i = 0; i < wlog.size() && i < exp_writes.size(); i++) begin
            check($sformatf("log_addr_%0d", i), wlog[i].addr, exp_writes[i].addr);
            check($sformatf("log_data_%0d", i), wlog[i].data, exp_writes[i].data);
        end
        for (int i = 0; i < 16; i++) begin
            check($sformatf("mem_word_%0d", i), dm[i], exp_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
